// File: rtl/bus_interface_unit.sv
// Bus interface unit: arbitrates core data accesses and instruction prefetch onto one
// external bidirectional memory bus with wait-state handshake, timeout and prefetch FIFO.
module bus_interface_unit #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 16,
  parameter int PREFETCH_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req_valid,
  output logic              core_req_ready,
  input  logic              core_req_write,
  input  logic [ADDR_W-1:0] core_req_addr,
  input  logic [DATA_W-1:0] core_req_wdata,
  output logic              core_rsp_valid,
  output logic [DATA_W-1:0] core_rsp_rdata,
  output logic              core_rsp_err,
  input  logic              fetch_flush,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              fetch_ready,
  output logic              fetch_err,
  inout  wire  [DATA_W-1:0] data_bus,
  output logic [ADDR_W-1:0] addr_bus,
  output logic              mem_read,
  output logic              mem_write,
  input  logic              mem_ready,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, DREAD, DWRITE, FETCH} state_t;

  localparam int PTR_W = $clog2(PREFETCH_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(PREFETCH_DEPTH);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic                busy_q, busy_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0]   fetch_addr_q, fetch_addr_d;
  logic                fetch_err_q, fetch_err_d;
  logic                discard_q, discard_d;
  logic [DATA_W-1:0]   fifo_q [PREFETCH_DEPTH];
  logic [DATA_W-1:0]   fifo_d [PREFETCH_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                push, pop, done, abort;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    busy_d       = busy_q;
    tmo_d        = tmo_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = '0;
    rsp_err_d    = 1'b0;
    fetch_addr_d = fetch_addr_q;
    fetch_err_d  = fetch_err_q;
    discard_d    = discard_q;
    push         = 1'b0;
    done         = 1'b0;
    abort        = 1'b0;

    case (state_q)
      IDLE: begin
        if (core_req_valid) begin
          state_d     = core_req_write ? DWRITE : DREAD;
          addr_d      = core_req_addr;
          wdata_d     = core_req_wdata;
          mem_read_d  = !core_req_write;
          mem_write_d = core_req_write;
          busy_d      = 1'b1;
          tmo_d       = '0;
        end else if (!fetch_err_q && (count_q < FIFO_FULL) && !fetch_flush) begin
          state_d    = FETCH;
          addr_d     = fetch_addr_q;
          mem_read_d = 1'b1;
          busy_d     = 1'b1;
          tmo_d      = '0;
          discard_d  = 1'b0;
        end
      end
      default: begin
        done  = mem_ready;
        abort = !mem_ready && (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);
        if (TIMEOUT_CYCLES != 0) tmo_d = tmo_q + TMO_W'(1);
        if (done || abort) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          busy_d      = 1'b0;
          if (state_q == FETCH) begin
            // A fetch overtaken by a flush belongs to the old stream: drop data and error.
            if (!discard_q && !fetch_flush) begin
              if (done) begin
                push         = 1'b1;
                fetch_addr_d = fetch_addr_q + ADDR_W'(1);
              end else begin
                fetch_err_d = 1'b1;
              end
            end
            discard_d = 1'b0;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = abort;
            if ((state_q == DREAD) && done) rsp_rdata_d = data_bus;
          end
        end else if ((state_q == FETCH) && fetch_flush) begin
          discard_d = 1'b1;
        end
      end
    endcase

    if (fetch_flush) begin
      fetch_addr_d = fetch_pc;
      fetch_err_d  = 1'b0;
    end
  end

  always_comb begin
    pop      = (count_q != '0) && fetch_ready;
    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (fetch_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q] = data_bus;
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      busy_q       <= 1'b0;
      tmo_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      fetch_addr_q <= '0;
      fetch_err_q  <= 1'b0;
      discard_q    <= 1'b0;
      fifo_q       <= '{default: '0};
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      busy_q       <= busy_d;
      tmo_q        <= tmo_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      fetch_addr_q <= fetch_addr_d;
      fetch_err_q  <= fetch_err_d;
      discard_q    <= discard_d;
      fifo_q       <= fifo_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  assign data_bus       = mem_write_q ? wdata_q : 'z;
  assign core_req_ready = (state_q == IDLE);
  assign core_rsp_valid = rsp_valid_q;
  assign core_rsp_rdata = rsp_rdata_q;
  assign core_rsp_err   = rsp_err_q;
  assign fetch_valid    = (count_q != '0);
  assign fetch_data     = fifo_q[rd_ptr_q];
  assign fetch_err      = fetch_err_q;
  assign addr_bus       = addr_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign busy           = busy_q;

endmodule
